// File: rtl/gate_truth_sweep.sv
// N-input logic gate with a truth-table sweep engine: streams every input vector
// and its gate output over a valid/ready handshake while building the table bitmap.
module gate_truth_sweep #(
    parameter int N_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [N_IN-1:0]      row_in,
    output logic                 row_out,
    output logic [2**N_IN-1:0]   table_q
);
    localparam int DEPTH = 2 ** N_IN;
    // idx carries one spare bit so the last increment can never alias row 0
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [N_IN:0]     idx_q;
    logic [2:0]        op_q;
    logic [DEPTH-1:0]  tbl_q;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign row_valid = (state_q == RUN);
    assign row_in    = idx_q[N_IN-1:0];
    assign table_q   = tbl_q;

    always_comb begin
        row_out = 1'b0;
        case (op_q)
            3'd0: row_out = ~&row_in;
            3'd1: row_out = &row_in;
            3'd2: row_out = |row_in;
            3'd3: row_out = ~|row_in;
            3'd4: row_out = ^row_in;
            3'd5: row_out = ~^row_in;
            3'd6: row_out = row_in[0];
            3'd7: row_out = ~row_in[0];
            default: row_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            tbl_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        idx_q   <= '0;
                        tbl_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (row_ready) begin
                        tbl_q[row_in] <= row_out;
                        if (idx_q == LAST_IDX) state_q <= DONE;
                        else                   idx_q   <= idx_q + 1'b1;
                    end
                    // abort wins over the DONE transition, after the row is written
                    if (abort) state_q <= IDLE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_truth_sweep.sv
// Scoreboard bench: driver pushes expected rows, negedge monitors pop on each handshake.
module tb_gate_truth_sweep;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, abort_a, ready_a;
    logic [2:0] op_a;
    logic       busy_a, done_a, row_valid_a, row_out_a;
    logic [1:0] row_in_a;
    logic [3:0] table_a;

    logic       rst_b, start_b, abort_b, ready_b;
    logic [2:0] op_b;
    logic       busy_b, done_b, row_valid_b, row_out_b;
    logic [2:0] row_in_b;
    logic [7:0] table_b;

    gate_truth_sweep #(.N_IN(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .op(op_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .row_valid(row_valid_a), .row_ready(ready_a),
        .row_in(row_in_a), .row_out(row_out_a), .table_q(table_a)
    );

    gate_truth_sweep #(.N_IN(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .op(op_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .row_valid(row_valid_b), .row_ready(ready_b),
        .row_in(row_in_b), .row_out(row_out_b), .table_q(table_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int q_a[$];
    int q_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int e_a, e_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: expected rows are encoded as (index << 1) | output
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (row_valid_a && ready_a && !rst_a) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rowA: got row %0d out %0d, expected no row", row_in_a, row_out_a);
            end else begin
                e_a = q_a.pop_front();
                check("rowA", {29'd0, row_in_a, row_out_a}, e_a);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) done_cnt_b++;
        if (row_valid_b && ready_b && !rst_b) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rowB: got row %0d out %0d, expected no row", row_in_b, row_out_b);
            end else begin
                e_b = q_b.pop_front();
                check("rowB", {28'd0, row_in_b, row_out_b}, e_b);
            end
        end
    end

    task automatic push4(input logic [3:0] tbl);
        for (int i = 0; i < 4; i++) q_a.push_back(i * 2 + int'(tbl[i]));
    endtask

    task automatic push8(input logic [7:0] tbl);
        for (int i = 0; i < 8; i++) q_b.push_back(i * 2 + int'(tbl[i]));
    endtask

    task automatic start_sweep_a(input logic [2:0] o);
        @(posedge clk); #1 start_a = 1'b1; op_a = o;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin cyc = n; break; end
        end
    endtask

    task automatic wait_row_a(input int r);
        for (int n = 0; n < 40; n++) begin
            if (row_valid_a && int'(row_in_a) == r) return;
            @(posedge clk); #1;
        end
        check("wait_rowA_timeout", 0, 1);
    endtask

    task automatic sweep_b(input logic [2:0] o, input logic [7:0] exp_tbl);
        int c0, cyc;
        push8(exp_tbl);
        c0 = done_cnt_b;
        @(posedge clk); #1 start_b = 1'b1; op_b = o;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_b) begin cyc = n; break; end
        end
        check("b_done_latency", cyc, 9);
        repeat (2) @(negedge clk);
        check("b_table", table_b, exp_tbl);
        check("b_done_once", done_cnt_b - c0, 1);
        check("b_idle", busy_b, 0);
    endtask

    initial begin
        int c0, cyc;
        rst_a = 1; start_a = 0; abort_a = 0; ready_a = 1; op_a = 3'd5;
        rst_b = 1; start_b = 0; abort_b = 0; ready_b = 1; op_b = 3'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", row_valid_a, 0);
        check("rst_row_in", row_in_a, 0);
        check("rst_table", table_a, 0);
        check("rst_table_b", table_b, 0);
        @(posedge clk); #1 rst_a = 0; rst_b = 0;

        // T1: NAND, ready held high
        push4(4'b0111);
        c0 = done_cnt_a;
        start_sweep_a(3'd0);
        wait_done_a(cyc);
        check("t1_done_latency", cyc, 5);
        repeat (2) @(negedge clk);
        check("t1_table", table_a, 4'b0111);
        check("t1_done_once", done_cnt_a - c0, 1);
        check("t1_idle", busy_a, 0);

        // T3: backpressure on row 2
        push4(4'b0111);
        c0 = done_cnt_a;
        start_sweep_a(3'd0);
        wait_row_a(2);
        ready_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", row_valid_a, 1);
            check("t3_hold_in", row_in_a, 2);
            check("t3_hold_out", row_out_a, 1);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        wait_done_a(cyc);
        check("t3_done_seen", cyc > 0, 1);
        repeat (2) @(negedge clk);
        check("t3_table", table_a, 4'b0111);
        check("t3_done_once", done_cnt_a - c0, 1);

        // T4: start and op changed during RUN are ignored
        push4(4'b1000);
        c0 = done_cnt_a;
        start_sweep_a(3'd1);
        @(posedge clk); #1 start_a = 1'b1; op_a = 3'd2;
        repeat (2) @(posedge clk);
        #1 start_a = 1'b0;
        wait_done_a(cyc);
        check("t4_done_seen", cyc > 0, 1);
        repeat (2) @(negedge clk);
        check("t4_table", table_a, 4'b1000);
        check("t4_done_once", done_cnt_a - c0, 1);
        check("t4_idle", busy_a, 0);

        // T5: reset during row 1, then a fresh sweep
        q_a.push_back(0 * 2 + 1);
        c0 = done_cnt_a;
        start_sweep_a(3'd0);
        wait_row_a(1);
        rst_a = 1'b1;
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
        check("t5_busy", busy_a, 0);
        check("t5_valid", row_valid_a, 0);
        check("t5_table", table_a, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt_a - c0, 0);
        push4(4'b0111);
        start_sweep_a(3'd0);
        wait_done_a(cyc);
        check("t5_resweep_latency", cyc, 5);
        repeat (2) @(negedge clk);
        check("t5_resweep_table", table_a, 4'b0111);

        // T6: abort with the handshake of row 2 (AND)
        q_a.push_back(0); q_a.push_back(2); q_a.push_back(4);
        c0 = done_cnt_a;
        start_sweep_a(3'd1);
        wait_row_a(2);
        abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        check("t6_busy", busy_a, 0);
        check("t6_valid", row_valid_a, 0);
        check("t6_table", table_a, 4'b0000);
        repeat (3) @(negedge clk);
        check("t6_no_done", done_cnt_a - c0, 0);

        // T7: abort with the handshake of the final row (AND) writes bit 3, no done
        push4(4'b1000);
        c0 = done_cnt_a;
        start_sweep_a(3'd1);
        wait_row_a(3);
        abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        check("t7_busy", busy_a, 0);
        check("t7_table", table_a, 4'b1000);
        repeat (3) @(negedge clk);
        check("t7_no_done", done_cnt_a - c0, 0);

        // T2: 3-input sweeps
        sweep_b(3'd4, 8'h96);
        sweep_b(3'd3, 8'h01);
        sweep_b(3'd6, 8'hAA);

        repeat (2) @(negedge clk);
        check("qA_drained", q_a.size(), 0);
        check("qB_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
